// File: rtl/common_param.sv
// Shared MIPS decode constants and the control-bundle layout used by the
// instruction-decode stage and anything downstream that consumes its outputs.
package common_param;

    // Primary opcodes (Ins[31:26])
    localparam logic [5:0] OP_R_FORM = 6'h00;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-form function codes (Ins[5:0]); passed through for the ALU decoder
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IMM_ZERO,
        IMM_SEXT,
        IMM_ZEXT,
        IMM_LUI
    } imm_sel_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_RD,
        RD_RT
    } rd_sel_e;

    // Control bundle, MSB first in this order
    typedef struct packed {
        logic regwrite;
        logic alusrc;
        logic memread;
        logic memwrite;
        logic branch;
        logic illegal;
    } ctrl_t;

    // Instructions whose rt field is a source operand (others use rt as destination)
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_R_FORM) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with register 0 hard-wired to zero and
// optional same-cycle forwarding of the write port onto the read ports.
module id_regfile #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    // NOTE: the array is reset here because architectural state must read back
    // zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0) begin
            return '0;
        end else if ((BYPASS != 0) && we && (waddr == ra)) begin
            return wdata;
        end else begin
            return mem_q[ra];
        end
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: rtl/id_pipe_stage.sv
// MIPS instruction-decode pipeline stage: register read, load-use hazard
// detection, control/immediate decode and a valid/ready output register.
module id_pipe_stage
    import common_param::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Ins,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [5:0]      out_op,
    output logic [5:0]      out_func,
    output logic            out_regwrite,
    output logic            out_alusrc,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_illegal
);

    localparam int AW = $clog2(NREG);

    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            unused_shamt;

    assign op           = Ins[31:26];
    assign rs           = Ins[25:21];
    assign rt           = Ins[20:16];
    assign unused_shamt = ^Ins[10:6];

    id_regfile #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_regfile (
        .clk    (CLK),
        .rst_n  (RST),
        .we     (wb_en),
        .waddr  (wb_addr[AW-1:0]),
        .wdata  (wb_data),
        .raddr1 (rs[AW-1:0]),
        .raddr2 (rt[AW-1:0]),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // ---------------- decode ----------------
    ctrl_t           ctrl;
    imm_sel_e        imm_sel;
    rd_sel_e         rd_sel;
    logic [4:0]      rd_dec;
    logic [XLEN-1:0] imm_dec;

    always_comb begin
        ctrl    = '0;
        imm_sel = IMM_ZERO;
        rd_sel  = RD_NONE;
        case (op)
            OP_R_FORM: begin
                ctrl.regwrite = 1'b1;
                rd_sel        = RD_RD;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm_sel       = IMM_SEXT;
                rd_sel        = RD_RT;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm_sel       = IMM_ZEXT;
                rd_sel        = RD_RT;
            end
            OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm_sel       = IMM_LUI;
                rd_sel        = RD_RT;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm_sel       = IMM_SEXT;
                rd_sel        = RD_RT;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm_sel       = IMM_SEXT;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                imm_sel     = IMM_SEXT;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase

        case (rd_sel)
            RD_RD:   rd_dec = Ins[15:11];
            RD_RT:   rd_dec = rt;
            default: rd_dec = 5'd0;
        endcase

        // A write to $0 is architecturally a no-op, so drop it here
        if (rd_dec == 5'd0) begin
            ctrl.regwrite = 1'b0;
        end

        case (imm_sel)
            IMM_SEXT: imm_dec = XLEN'(signed'(Ins[15:0]));
            IMM_ZEXT: imm_dec = XLEN'(Ins[15:0]);
            IMM_LUI:  imm_dec = XLEN'(signed'({Ins[15:0], 16'h0000}));
            default:  imm_dec = '0;
        endcase
    end

    // ---------------- hazard and handshake ----------------
    logic out_valid_q;
    logic hz;
    logic accept;

    assign hz = ex_load_valid && (ex_load_rd != 5'd0) &&
                ((ex_load_rd == rs) || ((ex_load_rd == rt) && reads_rt(op)));

    assign in_ready = (!out_valid_q || out_ready) && !hz && !flush;
    assign accept   = in_valid && in_ready;

    // ---------------- output register ----------------
    logic            out_valid_d;
    logic [XLEN-1:0] rdata1_q, rdata1_d;
    logic [XLEN-1:0] rdata2_q, rdata2_d;
    logic [XLEN-1:0] imm_q,    imm_d;
    logic [4:0]      rd_q,     rd_d;
    logic [5:0]      op_q,     op_d;
    logic [5:0]      func_q,   func_d;
    ctrl_t           ctrl_q,   ctrl_d;

    always_comb begin
        out_valid_d = out_valid_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        op_d        = op_q;
        func_d      = func_q;
        ctrl_d      = ctrl_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rdata1_d    = rdata1;
            rdata2_d    = rdata2;
            imm_d       = imm_dec;
            rd_d        = rd_dec;
            op_d        = op;
            func_d      = Ins[5:0];
            ctrl_d      = ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking '<=' so every flop
    // samples its input from before the clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q <= 1'b0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
            op_q        <= '0;
            func_q      <= '0;
            ctrl_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
            func_q      <= func_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rdata1   = rdata1_q;
    assign out_rdata2   = rdata2_q;
    assign out_imm      = imm_q;
    assign out_rd       = rd_q;
    assign out_op       = op_q;
    assign out_func     = func_q;
    assign out_regwrite = ctrl_q.regwrite;
    assign out_alusrc   = ctrl_q.alusrc;
    assign out_memread  = ctrl_q.memread;
    assign out_memwrite = ctrl_q.memwrite;
    assign out_branch   = ctrl_q.branch;
    assign out_illegal  = ctrl_q.illegal;

endmodule

// File: doc/id_pipe_stage.md
ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width (>=16).
REQ-002 Parameter NREG, default 32, number of architectural registers (power of 2, <=32); AW=log2(NREG).
REQ-003 Parameter BYPASS, default 1, enables write-back-to-read forwarding when 1.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 RST  in  1  asynchronous reset, active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-007 Ins  in  32  MIPS instruction word.
REQ-008 wb_en, wb_addr, wb_data  in  1, 5, XLEN  register write-back port.
REQ-009 ex_load_valid, ex_load_rd  in  1, 5  load currently in EX stage and its destination.
REQ-010 flush  in  1  discard the instruction held in the output register.
REQ-011 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-012 out_rdata1, out_rdata2, out_imm  out  XLEN each  rs value, rt value, extended immediate.
REQ-013 out_rd, out_op, out_func  out  5, 6, 6  destination register, opcode, function field.
REQ-014 out_regwrite, out_alusrc, out_memread, out_memwrite, out_branch, out_illegal  out  1 each  decoded controls.

Function
REQ-015 Register file: NREG x XLEN; register 0 reads zero always, writes to it ignored; wb_addr bits above AW ignored.
REQ-016 Write: on CLK rise when wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data.
REQ-017 Read: rs=Ins[25:21], rt=Ins[20:16]; with BYPASS=1 and wb_en=1, wb_addr==rs (or rt) and !=0, read value is wb_data in same cycle; with BYPASS=0 read returns old array value.
REQ-018 Hazard: hz=ex_load_valid & ex_load_rd!=0 & (ex_load_rd==rs | (ex_load_rd==rt & instruction reads rt)); R_FORM, BEQ, BNE, SW read rt.
REQ-019 in_ready = (!out_valid | out_ready) & !hz; combinational, never depends on in_valid.
REQ-020 Accept when in_valid & in_ready: all out_* registered on next CLK rise, latency exactly 1 cycle, out_valid <= 1.
REQ-021 Output register holds all out_* stable while out_valid & !out_ready.
REQ-022 out_valid <= 0 when out_ready & no accept; back-to-back accepts give one instruction per cycle.
REQ-023 flush=1: out_valid <= 0 next cycle, in_ready forced 0 that cycle; flush wins over simultaneous accept.
REQ-024 R_FORM (op 0): rd=Ins[15:11], regwrite=1, alusrc=0, imm=0.
REQ-025 ADDI, ADDIU, SLTI, SLTIU: rd=rt, regwrite=1, alusrc=1, imm=sign-extend(Ins[15:0]) to XLEN.
REQ-026 ANDI, ORI, XORI: as REQ-025 but zero-extend; LUI: imm={Ins[15:0],16'b0} sign-extended to XLEN.
REQ-027 LW: rd=rt, regwrite=1, memread=1, alusrc=1, sign-extend; SW: memwrite=1, alusrc=1, regwrite=0, sign-extend.
REQ-028 BEQ, BNE: branch=1, regwrite=0, alusrc=0, sign-extend.
REQ-029 Any other opcode: illegal=1, all other controls 0, rd=0; instruction still flows with out_valid.
REQ-030 Any decoded rd==0: out_regwrite=0.

Reset
REQ-031 RST=0 asynchronously clears all register-file entries and all out_* to 0; out_valid=0.
REQ-032 Reset mid-operation discards the held instruction; in_ready may be 1 on the first cycle after release.

Structure
REQ-033 Opcode and function constants (R_FORM, ADD, ADDI, LW, SW, BEQ, ...) and the control-bundle field order live in shared common_param.
REQ-034 One sub-module: id_regfile (parametrised NREG/XLEN, 2 read, 1 write, bypass); decode and pipeline register in top.

Verification
REQ-035 After reset, write reg10=5, reg11=7; ADD $9,$10,$11 -> next cycle out_rdata1=5, out_rdata2=7, out_rd=9, out_regwrite=1.
REQ-036 ADDI $8,$0,0xFFFF with XLEN=32 -> out_imm=0xFFFFFFFF; ORI same imm -> out_imm=0x0000FFFF; LUI 0x1234 -> 0x12340000.
REQ-037 wb_en=1 wb_addr=10 wb_data=0xAA in the accept cycle of ADD reading $10 -> out_rdata1=0xAA (BYPASS=1), old value (BYPASS=0).
REQ-038 ex_load_valid=1 ex_load_rd=11, ADD reads $11 -> in_ready=0 until ex_load_valid drops, then accepted once.
REQ-039 out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged, in_ready=0; flush asserted -> out_valid=0 next cycle.
REQ-040 Write to $0 with 0xFFFF then read $0 -> 0; opcode 0x3F -> out_illegal=1, out_regwrite=0.
